// File: rtl/muldiv.sv
`timescale 1ns/1ps
// muldiv: iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op       launch request (sampled when idle); 0=MULT 1=MULTU 2=DIV 3=DIVU
//   a, b            rs / rt operands, captured only on an accepted start
//   hi_we, lo_we    MTHI / MTLO strobes, honoured only when idle and not starting
//   wdata           MTHI / MTLO data
//   busy            operation in flight (RUN or FIX)
//   done            one-cycle pulse once HI/LO hold the new result
//   hi, lo          HI / LO registers
//
// Latency is DATA_WIDTH+1 cycles from the start edge to done.
// The multiply is a shift-add on magnitudes.
// The divide is a restoring divide on magnitudes.
// Signs are applied in the FIX cycle.
module muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;

    // Working datapath, meaningful only between start and FIX.
    // acc_q holds the multiply accumulator with the multiplier in its low half.
    // For a divide it holds the dividend, shifting out as quotient bits shift in.
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W:0]      rem_q, rem_d;
    logic [W-1:0]    opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic            is_div_q, is_div_d;
    logic            neg_q_q, neg_q_d;  // negate product / quotient
    logic            neg_r_q, neg_r_d;  // negate remainder
    logic            dz_q, dz_d;        // divisor was zero

    logic            start_ok;
    logic            sgn_op, sa, sb;
    logic [W-1:0]    amag, bmag;
    logic [W:0]      msum;
    logic [W:0]      dshift;
    logic            take;
    logic [2*W-1:0]  prod;

    // |x| in W+1 bits, so that -2^(W-1) becomes 2^(W-1) and still fits in W unsigned bits.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic is_signed);
        logic [W:0] ext;
        ext = {is_signed & x[W-1], x};
        if (ext[W]) ext = ~ext + {{W{1'b0}}, 1'b1};
        return ext[W-1:0];
    endfunction

    function automatic logic [W-1:0] negate_w(input logic [W-1:0] x, input logic en);
        return en ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;
    endfunction

    function automatic logic [2*W-1:0] negate_2w(input logic [2*W-1:0] x, input logic en);
        return en ? (~x + {{(2*W-1){1'b0}}, 1'b1}) : x;
    endfunction

    assign start_ok = (state_q == S_IDLE) && start;
    assign sgn_op   = ~op[0];
    assign sa       = sgn_op & a[W-1];
    assign sb       = sgn_op & b[W-1];
    assign amag     = magnitude(a, sgn_op);
    assign bmag     = magnitude(b, sgn_op);

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (acc_q[0]) is set, then shift right with carry.
    assign msum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});

    // One restoring step: bring in the next dividend bit, then subtract if it fits.
    // rem_q[W] stays clear for any in-range partial remainder.
    // OR-ing it in keeps the compare correct even if it were ever set.
    assign dshift = {rem_q[W-1:0], acc_q[W-1]};
    assign take   = rem_q[W] | (dshift >= {1'b0, opnd_q});

    assign prod = negate_2w(acc_q, neg_q_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d  = S_RUN;
                    cnt_d    = CW'(W - 1);
                    is_div_d = op[1];
                    acc_d    = {{W{1'b0}}, (op[1] ? amag : bmag)};
                    opnd_d   = op[1] ? bmag : amag;
                    rem_d    = '0;
                    neg_q_d  = sa ^ sb;
                    neg_r_d  = sa;
                    dz_d     = (b == '0);
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    rem_d = take ? (dshift - {1'b0, opnd_q}) : dshift;
                    acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], take};
                end else begin
                    acc_d = {msum, acc_q[W-1:1]};
                end
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // A zero divisor leaves the magnitude of a in the remainder.
                    // Re-applying a's sign gives HI = a.
                    // Only LO needs the explicit all-ones override.
                    hi_d = negate_w(rem_q[W-1:0], neg_r_q);
                    lo_d = dz_q ? {W{1'b1}} : negate_w(acc_q[W-1:0], neg_q_q);
                end else begin
                    hi_d = prod[2*W-1:W];
                    lo_d = prod[W-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        rem_q    <= rem_d;
        opnd_q   <= opnd_d;
        is_div_q <= is_div_d;
        neg_q_q  <= neg_q_d;
        neg_r_q  <= neg_r_d;
        dz_q     <= dz_d;
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
